// File: rtl/disp_page_ctl_pkg.sv
// Shared definitions for the display page controller: digit codes,
// page and edit-field encodings, FSM states and the page rotation helper.
package disp_page_ctl_pkg;

    localparam logic [3:0] BLANK    = 4'd15;
    localparam logic [3:0] LETTER_A = 4'd10;
    localparam logic [3:0] LETTER_P = 4'd11;
    localparam logic [3:0] LETTER_M = 4'd12;

    typedef enum logic [2:0] {
        PG_MIN_SEC   = 3'd0,
        PG_SEC       = 3'd1,
        PG_HOUR_AMPM = 3'd2,
        PG_HOUR_MIN  = 3'd3,
        PG_MONTH_DAY = 3'd4,
        PG_YEAR      = 3'd5,
        PG_BLANK6    = 3'd6,
        PG_BLANK7    = 3'd7
    } page_e;

    typedef enum logic [2:0] {
        FLD_SEC   = 3'd0,
        FLD_MIN   = 3'd1,
        FLD_HOUR  = 3'd2,
        FLD_DAY   = 3'd3,
        FLD_MONTH = 3'd4,
        FLD_YEAR  = 3'd5,
        FLD_RSV6  = 3'd6,
        FLD_RSV7  = 3'd7
    } field_e;

    typedef enum logic {
        ST_MANUAL = 1'b0,
        ST_AUTO   = 1'b1
    } state_e;

    // Auto rotation only cycles through the populated pages 0..5.
    function automatic page_e next_page(input page_e pg);
        return (pg >= PG_YEAR) ? PG_MIN_SEC : page_e'(pg + 3'd1);
    endfunction

endpackage

// File: rtl/disp_page_ctl_if.sv
// Time/date inputs, control strobes and display outputs of the page controller.
interface disp_page_ctl_if #(parameter int DIGITS = 4);

    logic                  tick_1hz;
    logic                  blink_tick;
    logic                  auto_en;
    logic [2:0]            mode_sel;
    logic                  hr12_en;
    logic                  edit_en;
    logic [2:0]            edit_field;
    logic [7:0]            sec_bcd;
    logic [7:0]            min_bcd;
    logic [7:0]            hour_bcd;
    logic [7:0]            day_bcd;
    logic [7:0]            month_bcd;
    logic [15:0]           year_bcd;
    logic [DIGITS*4-1:0]   bcd_out;
    logic [2:0]            page;
    logic                  pm;

    modport master (
        output tick_1hz, blink_tick, auto_en, mode_sel, hr12_en, edit_en, edit_field,
               sec_bcd, min_bcd, hour_bcd, day_bcd, month_bcd, year_bcd,
        input  bcd_out, page, pm
    );

    modport slave (
        input  tick_1hz, blink_tick, auto_en, mode_sel, hr12_en, edit_en, edit_field,
               sec_bcd, min_bcd, hour_bcd, day_bcd, month_bcd, year_bcd,
        output bcd_out, page, pm
    );

endinterface

// File: rtl/disp_page_ctl_hour12_conv.sv
// Combinational 24h -> 12h BCD hour conversion with PM flag.
// Non-BCD inputs give a defined but meaningless result.
module hour12_conv (
    input  logic [7:0] hour_bcd,
    output logic [7:0] hour12_bcd,
    output logic       pm
);

    logic [7:0] hour_bin;
    logic [7:0] hour_red;
    logic [7:0] unit_bin;

    // Go through binary so 20 -> 08 style borrows need no BCD adjust.
    always_comb begin
        hour_bin = {4'd0, hour_bcd[7:4]} * 8'd10 + {4'd0, hour_bcd[3:0]};
        pm       = (hour_bin >= 8'd12);
        if (hour_bin == 8'd0) begin
            hour_red = 8'd12;
        end else if (hour_bin > 8'd12) begin
            hour_red = hour_bin - 8'd12;
        end else begin
            hour_red = hour_bin;
        end
        if (hour_red >= 8'd10) begin
            unit_bin   = hour_red - 8'd10;
            hour12_bcd = {4'd1, unit_bin[3:0]};
        end else begin
            unit_bin   = hour_red;
            hour12_bcd = {4'd0, unit_bin[3:0]};
        end
    end

endmodule

// File: rtl/disp_page_ctl.sv
// Display page controller: selects which time/date page drives the BCD
// digits, rotates pages in auto mode and blanks the field being edited.
//
// state     | meaning
// ST_MANUAL | page follows mode_sel every cycle, hold counter idle
// ST_AUTO   | page rotates 0..5, advancing every PAGE_HOLD tick_1hz pulses
module disp_page_ctl
    import disp_page_ctl_pkg::*;
#(
    parameter int DIGITS    = 4,
    parameter int PAGE_HOLD = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    disp_page_ctl_if.slave    bus
);

    localparam logic [3:0] HOLD_LAST = 4'(PAGE_HOLD);

    state_e              state_q, state_nxt;
    page_e               page_q, page_nxt;
    logic [3:0]          hold_q, hold_nxt;
    logic                blink_q, blink_nxt;
    logic                pm_q, pm_nxt;
    logic [DIGITS*4-1:0] bcd_q, bcd_nxt;
    logic [7:0]          hr12_bcd;
    logic [7:0]          hr_page3;
    logic [15:0]         page_dig;
    logic [3:0]          blank_mask;

    hour12_conv u_hour12 (
        .hour_bcd   (bus.hour_bcd),
        .hour12_bcd (hr12_bcd),
        .pm         (pm_nxt)
    );

    // Mode FSM, page selection and hold counter.
    always_comb begin
        state_nxt = state_q;
        page_nxt  = page_q;
        hold_nxt  = hold_q;
        case (state_q)
            ST_MANUAL: begin
                hold_nxt = 4'd0;
                if (bus.auto_en) begin
                    state_nxt = ST_AUTO;
                    page_nxt  = PG_MIN_SEC;
                end else begin
                    page_nxt  = page_e'(bus.mode_sel);
                end
            end
            ST_AUTO: begin
                if (!bus.auto_en) begin
                    // Leaving auto wins over a coincident tick.
                    state_nxt = ST_MANUAL;
                    page_nxt  = page_e'(bus.mode_sel);
                    hold_nxt  = 4'd0;
                end else if (bus.tick_1hz && !bus.edit_en) begin
                    if (hold_q + 4'd1 == HOLD_LAST) begin
                        hold_nxt = 4'd0;
                        page_nxt = next_page(page_q);
                    end else begin
                        hold_nxt = hold_q + 4'd1;
                    end
                end
            end
            default: state_nxt = ST_MANUAL;
        endcase
    end

    // Blink phase runs only while a field is being edited.
    always_comb begin
        blink_nxt = 1'b0;
        if (bus.edit_en) begin
            blink_nxt = blink_q ^ bus.blink_tick;
        end
    end

    // Digit content of the page about to be shown, then edit blanking.
    // Built from next-state values so page and digits update together.
    always_comb begin
        hr_page3   = bus.hr12_en ? hr12_bcd : bus.hour_bcd;
        page_dig   = {4{BLANK}};
        blank_mask = 4'b0000;
        bcd_nxt    = {DIGITS{BLANK}};
        case (page_nxt)
            PG_MIN_SEC:   page_dig = {bus.min_bcd, bus.sec_bcd};
            PG_SEC:       page_dig = {BLANK, BLANK, bus.sec_bcd};
            PG_HOUR_AMPM: page_dig = {(pm_nxt ? LETTER_P : LETTER_A), LETTER_M, hr12_bcd};
            PG_HOUR_MIN:  page_dig = {hr_page3, bus.min_bcd};
            PG_MONTH_DAY: page_dig = {bus.month_bcd, bus.day_bcd};
            PG_YEAR:      page_dig = bus.year_bcd;
            default:      page_dig = {4{BLANK}};
        endcase
        if (bus.edit_en && blink_nxt) begin
            case (field_e'(bus.edit_field))
                FLD_SEC: begin
                    if (page_nxt == PG_MIN_SEC || page_nxt == PG_SEC) blank_mask = 4'b0011;
                end
                FLD_MIN: begin
                    if (page_nxt == PG_MIN_SEC)       blank_mask = 4'b1100;
                    else if (page_nxt == PG_HOUR_MIN) blank_mask = 4'b0011;
                end
                FLD_HOUR: begin
                    if (page_nxt == PG_HOUR_AMPM)     blank_mask = 4'b0011;
                    else if (page_nxt == PG_HOUR_MIN) blank_mask = 4'b1100;
                end
                FLD_DAY: begin
                    if (page_nxt == PG_MONTH_DAY) blank_mask = 4'b0011;
                end
                FLD_MONTH: begin
                    if (page_nxt == PG_MONTH_DAY) blank_mask = 4'b1100;
                end
                FLD_YEAR: begin
                    if (page_nxt == PG_YEAR) blank_mask = 4'b1111;
                end
                default: blank_mask = 4'b0000;
            endcase
        end
        for (int i = 0; i < 4; i++) begin
            bcd_nxt[i*4 +: 4] = blank_mask[i] ? BLANK : page_dig[i*4 +: 4];
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_MANUAL;
            page_q  <= PG_MIN_SEC;
            hold_q  <= 4'd0;
            blink_q <= 1'b0;
            pm_q    <= 1'b0;
            bcd_q   <= {DIGITS{BLANK}};
        end else begin
            state_q <= state_nxt;
            page_q  <= page_nxt;
            hold_q  <= hold_nxt;
            blink_q <= blink_nxt;
            pm_q    <= pm_nxt;
            bcd_q   <= bcd_nxt;
        end
    end

    assign bus.bcd_out = bcd_q;
    assign bus.page    = page_q;
    assign bus.pm      = pm_q;

endmodule

// File: tb/tb_disp_page_ctl.sv
// Self-checking bench for disp_page_ctl (DIGITS=4 and DIGITS=6 instances).
module tb_disp_page_ctl;
    import disp_page_ctl_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    disp_page_ctl_if #(.DIGITS(4)) bus ();
    disp_page_ctl_if #(.DIGITS(6)) bus6 ();

    disp_page_ctl #(.DIGITS(4), .PAGE_HOLD(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    disp_page_ctl #(.DIGITS(6), .PAGE_HOLD(3)) dut6 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus6)
    );

    typedef struct packed {
        logic [31:0] bcd;
        logic [2:0]  page;
        logic        pm;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   vectors     = 0;
    int   miscompares = 0;
    int   mpage;
    int   mhold;
    logic mphase;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic model_pm(input logic [7:0] h);
        int hr;
        hr = int'(h[7:4]) * 10 + int'(h[3:0]);
        return hr >= 12;
    endfunction

    function automatic logic [15:0] model_bcd(input int pg, input logic [7:0] s, mi, h, d, mo,
                                              input logic [15:0] y, input logic h12,
                                              input logic blank, input int fld);
        int hr, hh;
        logic [7:0]  hc, hp3;
        logic [15:0] r, m;
        hr  = int'(h[7:4]) * 10 + int'(h[3:0]);
        hh  = (hr % 12 == 0) ? 12 : hr % 12;
        hc  = {4'(hh / 10), 4'(hh % 10)};
        hp3 = h12 ? hc : h;
        case (pg)
            0:       r = {mi, s};
            1:       r = {8'hFF, s};
            2:       r = {(hr >= 12) ? LETTER_P : LETTER_A, LETTER_M, hc};
            3:       r = {hp3, mi};
            4:       r = {mo, d};
            5:       r = y;
            default: r = 16'hFFFF;
        endcase
        m = 16'h0000;
        if (blank) begin
            case (fld)
                0: if (pg == 0 || pg == 1) m = 16'h00FF;
                1: if (pg == 0) m = 16'hFF00; else if (pg == 3) m = 16'h00FF;
                2: if (pg == 2) m = 16'h00FF; else if (pg == 3) m = 16'hFF00;
                3: if (pg == 4) m = 16'h00FF;
                4: if (pg == 4) m = 16'hFF00;
                5: if (pg == 5) m = 16'hFFFF;
                default: m = 16'h0000;
            endcase
        end
        return r | m;
    endfunction

    function automatic logic [15:0] model_cur(input int pg);
        return model_bcd(pg, bus.sec_bcd, bus.min_bcd, bus.hour_bcd, bus.day_bcd, bus.month_bcd,
                         bus.year_bcd, bus.hr12_en, 1'b0, 0);
    endfunction

    task automatic test_reset();
        bus.mode_sel = 3'd1;
        bus.hour_bcd = 8'h15;
        #2 rst_n = 1'b0;
        #1;
        sb.push_back('{bcd: 32'h0000FFFF, page: 3'd0, pm: 1'b0});
        sb.push_back('{bcd: 32'h00FFFFFF, page: 3'd0, pm: 1'b0});
        e = sb.pop_front();
        vectors++;
        if ({32'(bus.bcd_out), bus.page, bus.pm} !== e) begin
            miscompares++;
            $display("FAIL reset_async4: got bcd=%h page=%0d pm=%b want bcd=%h page=%0d pm=%b",
                     bus.bcd_out, bus.page, bus.pm, e.bcd, e.page, e.pm);
        end
        e = sb.pop_front();
        vectors++;
        if ({32'(bus6.bcd_out), bus6.page, bus6.pm} !== e) begin
            miscompares++;
            $display("FAIL reset_async6: got bcd=%h page=%0d pm=%b want bcd=%h page=%0d pm=%b",
                     bus6.bcd_out, bus6.page, bus6.pm, e.bcd, e.page, e.pm);
        end
        step();
        step();
        sb.push_back('{bcd: 32'h0000FFFF, page: 3'd0, pm: 1'b0});
        e = sb.pop_front();
        vectors++;
        if ({32'(bus.bcd_out), bus.page, bus.pm} !== e) begin
            miscompares++;
            $display("FAIL reset_held: got bcd=%h page=%0d pm=%b want bcd=%h page=%0d pm=%b",
                     bus.bcd_out, bus.page, bus.pm, e.bcd, e.page, e.pm);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_manual();
        bus.mode_sel = 3'd3;
        bus.hour_bcd = 8'h21;
        bus.min_bcd  = 8'h45;
        bus.hr12_en  = 1'b0;
        sb.push_back('{bcd: 32'h00002145, page: 3'd3, pm: 1'b1});
        step();
        e = sb.pop_front();
        vectors++;
        if ({32'(bus.bcd_out), bus.page, bus.pm} !== e) begin
            miscompares++;
            $display("FAIL manual_hour_min: got bcd=%h page=%0d pm=%b want bcd=%h page=%0d pm=%b",
                     bus.bcd_out, bus.page, bus.pm, e.bcd, e.page, e.pm);
        end
        bus.sec_bcd   = 8'h37;
        bus.day_bcd   = 8'h28;
        bus.month_bcd = 8'h11;
        bus.year_bcd  = 16'h1999;
        for (int h12 = 0; h12 < 2; h12++) begin
            for (int pg = 0; pg < 8; pg++) begin
                bus.mode_sel = 3'(pg);
                bus.hr12_en  = 1'(h12);
                sb.push_back('{bcd: {16'h0, model_cur(pg)}, page: 3'(pg), pm: model_pm(bus.hour_bcd)});
                step();
                e = sb.pop_front();
                vectors++;
                if ({32'(bus.bcd_out), bus.page, bus.pm} !== e) begin
                    miscompares++;
                    $display("FAIL manual_page%0d_h12_%0d: got bcd=%h page=%0d pm=%b want bcd=%h page=%0d pm=%b",
                             pg, h12, bus.bcd_out, bus.page, bus.pm, e.bcd, e.page, e.pm);
                end
            end
        end
    endtask

    task automatic test_hour12();
        logic [7:0] hin [5]  = '{8'h00, 8'h12, 8'h13, 8'h20, 8'h23};
        logic [7:0] hout [5] = '{8'h12, 8'h12, 8'h01, 8'h08, 8'h11};
        logic [3:0] let_c [5] = '{LETTER_A, LETTER_P, LETTER_P, LETTER_P, LETTER_P};
        bus.mode_sel = 3'd2;
        bus.hr12_en  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.hour_bcd = hin[i];
            sb.push_back('{bcd: {16'h0, let_c[i], LETTER_M, hout[i]}, page: 3'd2, pm: (i != 0)});
            step();
            e = sb.pop_front();
            vectors++;
            if ({32'(bus.bcd_out), bus.page, bus.pm} !== e) begin
                miscompares++;
                $display("FAIL hour12_ampm_%h: got bcd=%h page=%0d pm=%b want bcd=%h page=%0d pm=%b",
                         hin[i], bus.bcd_out, bus.page, bus.pm, e.bcd, e.page, e.pm);
            end
        end
        bus.mode_sel = 3'd3;
        bus.hr12_en  = 1'b1;
        for (int h = 0; h < 24; h++) begin
            bus.hour_bcd = {4'(h / 10), 4'(h % 10)};
            sb.push_back('{bcd: {16'h0, model_cur(3)}, page: 3'd3, pm: (h >= 12)});
            step();
            e = sb.pop_front();
            vectors++;
            if ({32'(bus.bcd_out), bus.page, bus.pm} !== e) begin
                miscompares++;
                $display("FAIL hour12_page3_%0d: got bcd=%h page=%0d pm=%b want bcd=%h page=%0d pm=%b",
                         h, bus.bcd_out, bus.page, bus.pm, e.bcd, e.page, e.pm);
            end
        end
        bus.mode_sel = 3'd2;
        bus.hour_bcd = 8'hFF;
        step();
        vectors++;
        if ($isunknown({bus.bcd_out, bus.pm})) begin
            miscompares++;
            $display("FAIL hour12_nonbcd_noX: got bcd=%h pm=%b want no X", bus.bcd_out, bus.pm);
        end
        bus.hr12_en  = 1'b0;
        bus.hour_bcd = 8'h21;
    endtask

    task automatic auto_tick(input string tag);
        bus.tick_1hz = 1'b1;
        if (!bus.edit_en) begin
            mhold++;
            if (mhold == 3) begin
                mhold = 0;
                mpage = (mpage == 5) ? 0 : mpage + 1;
            end
        end
        sb.push_back('{bcd: {16'h0, model_cur(mpage)}, page: 3'(mpage), pm: model_pm(bus.hour_bcd)});
        step();
        bus.tick_1hz = 1'b0;
        e = sb.pop_front();
        vectors++;
        if ({32'(bus.bcd_out), bus.page, bus.pm} !== e) begin
            miscompares++;
            $display("FAIL %s: got bcd=%h page=%0d pm=%b want bcd=%h page=%0d pm=%b",
                     tag, bus.bcd_out, bus.page, bus.pm, e.bcd, e.page, e.pm);
        end
        step();
        step();
    endtask

    task automatic test_auto();
        bus.mode_sel = 3'd3;
        bus.auto_en  = 1'b1;
        mpage = 0;
        mhold = 0;
        sb.push_back('{bcd: {16'h0, model_cur(0)}, page: 3'd0, pm: model_pm(bus.hour_bcd)});
        step();
        e = sb.pop_front();
        vectors++;
        if ({32'(bus.bcd_out), bus.page, bus.pm} !== e) begin
            miscompares++;
            $display("FAIL auto_enter: got bcd=%h page=%0d pm=%b want bcd=%h page=%0d pm=%b",
                     bus.bcd_out, bus.page, bus.pm, e.bcd, e.page, e.pm);
        end
        for (int t = 0; t < 18; t++) auto_tick("auto_rotate");
        auto_tick("auto_pre_edit");
        bus.edit_en    = 1'b1;
        bus.edit_field = 3'd6;
        for (int t = 0; t < 5; t++) auto_tick("auto_edit_hold");
        bus.edit_en = 1'b0;
        for (int t = 0; t < 2; t++) auto_tick("auto_post_edit");
        // auto_en falls together with a tick: manual takes over
        bus.mode_sel = 3'd4;
        bus.auto_en  = 1'b0;
        bus.tick_1hz = 1'b1;
        sb.push_back('{bcd: {16'h0, model_cur(4)}, page: 3'd4, pm: model_pm(bus.hour_bcd)});
        step();
        bus.tick_1hz = 1'b0;
        e = sb.pop_front();
        vectors++;
        if ({32'(bus.bcd_out), bus.page, bus.pm} !== e) begin
            miscompares++;
            $display("FAIL auto_exit_tick: got bcd=%h page=%0d pm=%b want bcd=%h page=%0d pm=%b",
                     bus.bcd_out, bus.page, bus.pm, e.bcd, e.page, e.pm);
        end
        // rotate to page 4, then reset mid-cycle
        bus.auto_en  = 1'b1;
        bus.hour_bcd = 8'h15;
        mpage = 0;
        mhold = 0;
        step();
        for (int t = 0; t < 12; t++) auto_tick("auto_to_page4");
        #2 rst_n = 1'b0;
        #1;
        sb.push_back('{bcd: 32'h0000FFFF, page: 3'd0, pm: 1'b0});
        e = sb.pop_front();
        vectors++;
        if ({32'(bus.bcd_out), bus.page, bus.pm} !== e) begin
            miscompares++;
            $display("FAIL auto_reset_async: got bcd=%h page=%0d pm=%b want bcd=%h page=%0d pm=%b",
                     bus.bcd_out, bus.page, bus.pm, e.bcd, e.page, e.pm);
        end
        step();
        step();
        rst_n = 1'b1;
        mpage = 0;
        mhold = 0;
        sb.push_back('{bcd: {16'h0, model_cur(0)}, page: 3'd0, pm: 1'b1});
        step();
        e = sb.pop_front();
        vectors++;
        if ({32'(bus.bcd_out), bus.page, bus.pm} !== e) begin
            miscompares++;
            $display("FAIL auto_after_reset: got bcd=%h page=%0d pm=%b want bcd=%h page=%0d pm=%b",
                     bus.bcd_out, bus.page, bus.pm, e.bcd, e.page, e.pm);
        end
        for (int t = 0; t < 3; t++) auto_tick("auto_restart");
        bus.auto_en = 1'b0;
        step();
    endtask

    task automatic test_blink();
        logic [15:0] exp_dig;
        bus.mode_sel   = 3'd4;
        bus.day_bcd    = 8'h17;
        bus.month_bcd  = 8'h09;
        bus.edit_en    = 1'b1;
        bus.edit_field = 3'd3;
        mphase = 1'b0;
        for (int c = 0; c < 40; c++) begin
            bus.blink_tick = (c % 8 == 7);
            if (bus.blink_tick) mphase = ~mphase;
            exp_dig = mphase ? 16'h09FF : 16'h0917;
            sb.push_back('{bcd: {16'h0, exp_dig}, page: 3'd4, pm: model_pm(bus.hour_bcd)});
            step();
            bus.blink_tick = 1'b0;
            e = sb.pop_front();
            vectors++;
            if ({32'(bus.bcd_out), bus.page, bus.pm} !== e) begin
                miscompares++;
                $display("FAIL blink_day_c%0d: got bcd=%h page=%0d pm=%b want bcd=%h page=%0d pm=%b",
                         c, bus.bcd_out, bus.page, bus.pm, e.bcd, e.page, e.pm);
            end
        end
        // phase is now 1 after five toggles
        for (int k = 0; k < 6; k++) begin
            case (k)
                0: begin bus.edit_field = 3'd4; exp_dig = 16'hFF17; end
                1: begin bus.edit_field = 3'd2; exp_dig = 16'h0917; end
                2: begin bus.edit_en = 1'b0; exp_dig = 16'h0917; end
                3: begin bus.blink_tick = 1'b1; exp_dig = 16'h0917; end
                4: begin bus.edit_en = 1'b1; bus.edit_field = 3'd3; exp_dig = 16'h0917; end
                default: begin
                    bus.mode_sel = 3'd5; bus.edit_field = 3'd5; bus.blink_tick = 1'b1;
                    exp_dig = 16'hFFFF;
                end
            endcase
            sb.push_back('{bcd: {16'h0, exp_dig}, page: (k == 5) ? 3'd5 : 3'd4, pm: model_pm(bus.hour_bcd)});
            step();
            bus.blink_tick = 1'b0;
            e = sb.pop_front();
            vectors++;
            if ({32'(bus.bcd_out), bus.page, bus.pm} !== e) begin
                miscompares++;
                $display("FAIL blink_field_k%0d: got bcd=%h page=%0d pm=%b want bcd=%h page=%0d pm=%b",
                         k, bus.bcd_out, bus.page, bus.pm, e.bcd, e.page, e.pm);
            end
        end
        bus.edit_en = 1'b0;
        step();
    endtask

    task automatic test_digits6();
        logic [2:0]  sel [3]  = '{3'd5, 3'd7, 3'd0};
        logic [31:0] want [3] = '{32'h00FF2015, 32'h00FFFFFF, 32'h00FF5901};
        bus6.year_bcd = 16'h2015;
        bus6.min_bcd  = 8'h59;
        bus6.sec_bcd  = 8'h01;
        for (int i = 0; i < 3; i++) begin
            bus6.mode_sel = sel[i];
            sb.push_back('{bcd: want[i], page: sel[i], pm: 1'b0});
            step();
            e = sb.pop_front();
            vectors++;
            if ({32'(bus6.bcd_out), bus6.page, bus6.pm} !== e) begin
                miscompares++;
                $display("FAIL digits6_sel%0d: got bcd=%h page=%0d pm=%b want bcd=%h page=%0d pm=%b",
                         sel[i], bus6.bcd_out, bus6.page, bus6.pm, e.bcd, e.page, e.pm);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "timeout");
    end

    initial begin
        bus.tick_1hz   = 1'b0; bus6.tick_1hz   = 1'b0;
        bus.blink_tick = 1'b0; bus6.blink_tick = 1'b0;
        bus.auto_en    = 1'b0; bus6.auto_en    = 1'b0;
        bus.mode_sel   = 3'd0; bus6.mode_sel   = 3'd0;
        bus.hr12_en    = 1'b0; bus6.hr12_en    = 1'b0;
        bus.edit_en    = 1'b0; bus6.edit_en    = 1'b0;
        bus.edit_field = 3'd0; bus6.edit_field = 3'd0;
        bus.sec_bcd    = 8'h00; bus6.sec_bcd   = 8'h00;
        bus.min_bcd    = 8'h00; bus6.min_bcd   = 8'h00;
        bus.hour_bcd   = 8'h00; bus6.hour_bcd  = 8'h00;
        bus.day_bcd    = 8'h00; bus6.day_bcd   = 8'h00;
        bus.month_bcd  = 8'h00; bus6.month_bcd = 8'h00;
        bus.year_bcd   = 16'h0; bus6.year_bcd  = 16'h0;
        test_reset();
        test_manual();
        test_hour12();
        test_auto();
        test_blink();
        test_digits6();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/disp_page_ctl.md
DISP_PAGE_CTL -- requirements
Module: disp_page_ctl

Interface
REQ-001 Parameter DIGITS, default 4, number of BCD digits driven; legal range 4..8.
REQ-002 Parameter PAGE_HOLD, default 3, tick_1hz pulses each page is shown in auto mode; legal range 1..15.
REQ-003 Ports SHALL be:
  clk  in  1  system clock.
  rst_n  in  1  reset; one clock, asynchronous, active-low.
  tick_1hz  in  1  one-cycle enable pulse, page-hold time base.
  blink_tick  in  1  one-cycle enable pulse, toggles blink phase.
  auto_en  in  1  1 = auto-rotate pages, 0 = manual.
  mode_sel  in  3  manual page select.
  hr12_en  in  1  1 = 12-hour format on hour pages.
  edit_en  in  1  field-edit in progress.
  edit_field  in  3  field being edited: 0 sec, 1 min, 2 hour, 3 day, 4 month, 5 year.
  sec_bcd, min_bcd, hour_bcd, day_bcd, month_bcd  in  8 each  {tens,unit} BCD.
  year_bcd  in  16  {thou,hund,tens,unit} BCD.
  bcd_out  out  DIGITS*4  digit codes; digit 0 is bits [3:0], the rightmost digit.
  page  out  3  page currently displayed.
  pm  out  1  1 when hour_bcd >= 12.

Function
REQ-004 Pages, listed digit 3..0: 0 MIN_SEC = min_t,min_u,sec_t,sec_u; 1 SEC = BLANK,BLANK,sec_t,sec_u; 2 HOUR_AMPM = A-or-P,M,hr_t,hr_u; 3 HOUR_MIN = hr_t,hr_u,min_t,min_u; 4 MONTH_DAY = mon_t,mon_u,day_t,day_u; 5 YEAR = thou,hund,tens,unit; 6 and 7 = all BLANK.
REQ-005 Digits DIGITS-1..4 SHALL always be BLANK.
REQ-006 Hour digits SHALL be converted to 12-hour format on page 2 always, and on page 3 when hr12_en=1: 00->12; 01..12 unchanged; 13..23 -> hour-12 in valid BCD (e.g. 20->08, 22->10).
REQ-007 pm SHALL be 1 for hour 12..23 and 0 for hour 00..11, independent of page.
REQ-008 The FSM SHALL have two states: MANUAL and AUTO.
REQ-009 MANUAL->AUTO when auto_en=1: page is loaded with 0 and the hold counter is cleared in the same cycle.
REQ-010 AUTO->MANUAL when auto_en=0: page follows mode_sel from the next cycle.
REQ-011 In MANUAL, page SHALL be registered from mode_sel each cycle.
REQ-012 In AUTO, the hold counter SHALL increment on each tick_1hz. When it reaches PAGE_HOLD, it clears and page advances 0..5, wrapping 5->0; pages 6 and 7 are never visited.
REQ-013 The blink phase SHALL toggle on each blink_tick and clear to 0 whenever edit_en=0.
REQ-014 When edit_en=1, blink phase=1, and edit_field's digits are on the current page, those digits SHALL output BLANK; all other digits are unaffected.
REQ-015 In AUTO with edit_en=1, page advance SHALL be suppressed and the hold counter held.
REQ-016 bcd_out SHALL be registered, with 1-cycle latency from any input or page change to output.
REQ-017 Simultaneous tick_1hz and auto_en fall: the MANUAL transition wins and the tick is ignored.
REQ-018 Input BCD values are not range-checked; non-BCD hour values SHALL produce no X and leave the 12-hour digits unspecified.

Reset
REQ-019 With rst_n=0, regardless of clk: state=MANUAL, page=0, hold counter=0, blink phase=0, pm=0, bcd_out all BLANK.
REQ-020 Reset asserted mid-rotation SHALL abort rotation; after release the FSM enters AUTO from page 0 if auto_en=1.

Structure
REQ-021 Codes BLANK=4'd15, LETTER_A, LETTER_P, LETTER_M, page encodings, and field encodings SHALL live in the shared global definitions file.
REQ-022 12-hour conversion SHALL be a combinational sub-module hour12_conv (in 8-bit BCD hour; out 8-bit BCD hour, pm).

Verification
REQ-023 Reset, then mode_sel=3, hour=8'h21, min=8'h45, hr12_en=0 -> bcd_out[15:0]=2,1,4,5 one cycle later; page=3, pm=1.
REQ-024 mode_sel=2, hour values 00, 12, 13, 20, 23 -> hour digits 12, 12, 01, 08, 11; letters A,P,P,P,P.
REQ-025 auto_en=1, PAGE_HOLD=3, 18 tick_1hz pulses -> page sequence 0,1,2,3,4,5,0 with a change every 3rd tick.
REQ-026 mode_sel=4, edit_en=1, edit_field=3, blink_tick every 8 cycles -> digits 1..0 alternate BLANK/day value; digits 3..2 are steady.
REQ-027 DIGITS=6, mode_sel=5, year=16'h2015 -> bcd_out = F,F,2,0,1,5; mode_sel=7 -> all F.
REQ-028 Assert rst_n low during AUTO page 4 -> all outputs reach their reset values without a clk edge; after release with auto_en=1 -> page=0.
